tone_transmitter: RTL and testbench
===================================

# tone_transmitter

Generates the audio-tone command bursts that the robot's tone detector decodes. A 3-bit direction command (STOP, STRAIGHT, LEFT, RIGHT, BACK) arrives with a one-cycle `send` strobe. The block emits a square wave at the frequency assigned to that command for a fixed burst length. It then holds the line silent for a guard gap, so the far-end detector returns to its no-signal state before the next command. It sits between the control logic and the tone output pin/driver.

## Interface
- `HALF_STOP`, 12_500, half-period in clk cycles for STOP
- `HALF_STRAIGHT`, 10_000, half-period for STRAIGHT
- `HALF_LEFT`, 8_333, half-period for LEFT
- `HALF_RIGHT`, 7_143, half-period for RIGHT
- `HALF_BACK`, 6_250, half-period for BACK
- `BURST_CYCLES`, 25_000_000, tone duration in cycles. Must exceed the detector's 12_500_000-cycle qualification window.
- `GAP_CYCLES`, 5_000_000, silent guard interval after each burst
- All parameters ≥ 1. All counters are 32 bits.

Ports:
- `clk` input 1 system clock, all logic on rising edge
- `rst` input 1 — one clock; reset is asynchronous and active-high
- `cmd` input 3 command code: STOP=3'b100, STRAIGHT=3'b000, LEFT=3'b001, RIGHT=3'b010, BACK=3'b011
- `send` input 1 one-cycle request strobe, sampled only in IDLE
- `abort` input 1 cancels the burst or gap in progress
- `tone` output 1 square-wave output
- `busy` output 1 high from acceptance through the end of GAP
- `done` output 1 one-cycle pulse on normal completion
- `err` output 1 one-cycle pulse when `send` carries an invalid code
- `active_cmd` output 3 latched code of the current or last burst

## Operation
- Reset values: state=IDLE, `tone`=0, `busy`=0, `done`=0, `err`=0, `active_cmd`=3'b100. All counters are 0.
- States: IDLE, TONE, GAP.
- IDLE, `send`=1 with a valid `cmd`:
  - latch `cmd` into `active_cmd` and select the matching half-period
  - clear `half_cnt` and `burst_cnt`, set `tone`=0, go to TONE
- IDLE, `send`=1 with an invalid `cmd` (3'b101, 3'b110, 3'b111):
  - pulse `err` for one cycle, stay in IDLE
  - `active_cmd` is unchanged
- TONE, each cycle:
  - if `half_cnt`==HALF−1: toggle `tone`, clear `half_cnt`; otherwise increment `half_cnt`
  - if `burst_cnt`==BURST_CYCLES−1: go to GAP, force `tone`=0, clear `burst_cnt`; otherwise increment `burst_cnt`
- GAP, each cycle:
  - `tone` held at 0
  - if `burst_cnt`==GAP_CYCLES−1: go to IDLE and pulse `done`; otherwise increment
- `busy` is 1 whenever state is TONE or GAP.
- `send` during TONE or GAP is ignored: no queueing, no `err`.
- `abort` in TONE or GAP:
  - next state IDLE, `tone`=0, counters cleared
  - no `done` pulse
- `abort` in IDLE has no effect. `send`+`abort` together in IDLE: the send is accepted.
- `abort` has priority over burst-end and gap-end in the same cycle, so no `done` pulse occurs.
- Async `rst` at any point forces all reset values immediately. The in-progress burst is lost.

## Timing
- `send` sampled at the edge ending cycle N → TONE, `busy`=1, `tone`=0 in cycle N+1.
- First `tone` transition in cycle N+1+HALF, then every HALF cycles. Output period is 2×HALF cycles.
- TONE lasts exactly BURST_CYCLES cycles: N+1 … N+BURST.
- GAP lasts exactly GAP_CYCLES cycles.
- Completion: `done`=1 and `busy`=0 in cycle N+BURST+GAP+1. A new `send` may be accepted in that same cycle.
- `err` and `done` are registered one-cycle pulses.

## Test plan
Bench parameters: HALF = 2/3/4/5/6 for STOP/STRAIGHT/LEFT/RIGHT/BACK, BURST=20, GAP=5.

- **Basic STRAIGHT burst.** `send` with `cmd`=3'b000 at cycle 0.
  - `busy`=1 in cycles 1–25.
  - `tone` toggles in cycles 4, 7, 10, 13, 16, 19.
  - `tone`=0 in cycles 21–25.
  - `done`=1 only in cycle 26, where `busy`=0. `active_cmd`=3'b000.
- **Frequency mapping.** Send each of STOP/LEFT/RIGHT/BACK in turn.
  - Measured high-time = 2/4/5/6 cycles respectively.
  - `active_cmd` matches each sent code.
- **Invalid code.** `send` with `cmd`=3'b111 in IDLE.
  - `err`=1 for exactly one cycle.
  - `busy` stays 0, `active_cmd` unchanged, `tone`=0.
- **Send while busy.** Second `send` (LEFT) at cycle 10 of a STRAIGHT burst.
  - Ignored: the burst is still STRAIGHT and `done` still arrives in cycle 26.
  - A `send` in cycle 26 is accepted, giving `busy`=1 in cycle 27.
- **Abort.**
  - `abort` at cycle 8 (TONE) → cycle 9: IDLE, `tone`=0, `busy`=0, no `done` ever.
  - Repeat with `abort` at cycle 25 (last GAP cycle) → no `done`.
- **Reset mid-burst.** Assert `rst` asynchronously mid-cycle 12.
  - Outputs immediately: `tone`=0, `busy`=0, `active_cmd`=3'b100.
  - After release, a fresh `send` gives the standard cycle-accurate sequence.

Source files
------------

// File: rtl/tone_transmitter.sv
// tone_transmitter: emits a fixed-length square-wave burst whose frequency
// encodes a 3-bit direction command, then holds the line silent for a guard gap.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   cmd[2:0]   - command code (STOP=100, STRAIGHT=000, LEFT=001, RIGHT=010, BACK=011)
//   send       - one-cycle request strobe, honoured only in IDLE
//   abort      - cancels a burst or gap in progress
//   tone       - square-wave output
//   busy       - high while a burst or its guard gap is in progress
//   done       - one-cycle pulse on normal completion
//   err        - one-cycle pulse when send carries an invalid code
//   active_cmd - code of the current or last accepted burst
module tone_transmitter #(
    parameter int unsigned HALF_STOP     = 12_500,
    parameter int unsigned HALF_STRAIGHT = 10_000,
    parameter int unsigned HALF_LEFT     = 8_333,
    parameter int unsigned HALF_RIGHT    = 7_143,
    parameter int unsigned HALF_BACK     = 6_250,
    parameter int unsigned BURST_CYCLES  = 25_000_000,
    parameter int unsigned GAP_CYCLES    = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] cmd,
    input  logic       send,
    input  logic       abort,
    output logic       tone,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] active_cmd
);

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    localparam logic [31:0] BURST_LAST = 32'(BURST_CYCLES - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] half_cnt_q, half_cnt_d;
    logic [31:0] burst_cnt_q, burst_cnt_d;
    logic [31:0] half_q, half_d;
    logic        tone_q, tone_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [2:0]  cmd_q, cmd_d;

    logic        cmd_ok;
    logic [31:0] half_sel;

    always_comb begin
        cmd_ok   = 1'b1;
        half_sel = 32'(HALF_STOP);
        case (cmd)
            3'b100:  half_sel = 32'(HALF_STOP);
            3'b000:  half_sel = 32'(HALF_STRAIGHT);
            3'b001:  half_sel = 32'(HALF_LEFT);
            3'b010:  half_sel = 32'(HALF_RIGHT);
            3'b011:  half_sel = 32'(HALF_BACK);
            default: cmd_ok   = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        half_cnt_d  = half_cnt_q;
        burst_cnt_d = burst_cnt_q;
        half_d      = half_q;
        tone_d      = tone_q;
        cmd_d       = cmd_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                tone_d      = 1'b0;
                half_cnt_d  = '0;
                burst_cnt_d = '0;
                if (send) begin
                    if (cmd_ok) begin
                        cmd_d   = cmd;
                        half_d  = half_sel;
                        state_d = TONE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            TONE: begin
                if (abort) begin
                    state_d     = IDLE;
                    tone_d      = 1'b0;
                    half_cnt_d  = '0;
                    burst_cnt_d = '0;
                end else begin
                    if (half_cnt_q == half_q - 32'd1) begin
                        tone_d     = ~tone_q;
                        half_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + 32'd1;
                    end
                    // Burst end wins over a coincident toggle: the gap starts low.
                    if (burst_cnt_q == BURST_LAST) begin
                        state_d     = GAP;
                        tone_d      = 1'b0;
                        half_cnt_d  = '0;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + 32'd1;
                    end
                end
            end
            GAP: begin
                tone_d = 1'b0;
                if (abort) begin
                    state_d     = IDLE;
                    half_cnt_d  = '0;
                    burst_cnt_d = '0;
                end else if (burst_cnt_q == GAP_LAST) begin
                    state_d     = IDLE;
                    done_d      = 1'b1;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + 32'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                tone_d      = 1'b0;
                half_cnt_d  = '0;
                burst_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            half_cnt_q  <= '0;
            burst_cnt_q <= '0;
            half_q      <= 32'(HALF_STOP);
            tone_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            cmd_q       <= 3'b100;
        end else begin
            state_q     <= state_d;
            half_cnt_q  <= half_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            half_q      <= half_d;
            tone_q      <= tone_d;
            done_q      <= done_d;
            err_q       <= err_d;
            cmd_q       <= cmd_d;
        end
    end

    assign tone       = tone_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign active_cmd = cmd_q;

endmodule

// File: tb/tb_tone_transmitter.sv
// Testbench for tone_transmitter: directed bursts with a scoreboard of
// expected output events (busy/tone edges, done and err pulses).
module tb_tone_transmitter;

    localparam int B = 20;
    localparam int G = 5;

    localparam int EV_BUSY = 0;
    localparam int EV_TOG  = 1;
    localparam int EV_DONE = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic       val;
        logic [2:0] cmd;
    } ev_t;

    logic       clk;
    logic       rst;
    logic [2:0] cmd;
    logic       send;
    logic       abort;
    logic       tone;
    logic       busy;
    logic       done;
    logic       err;
    logic [2:0] active_cmd;

    ev_t        q[$];
    int         gcyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    logic [2:0] last_cmd = 3'b100;
    logic       mb = 1'b0;
    logic       mt = 1'b0;

    tone_transmitter #(
        .HALF_STOP(2), .HALF_STRAIGHT(3), .HALF_LEFT(4),
        .HALF_RIGHT(5), .HALF_BACK(6),
        .BURST_CYCLES(B), .GAP_CYCLES(G)
    ) dut (
        .clk(clk), .rst(rst), .cmd(cmd), .send(send), .abort(abort),
        .tone(tone), .busy(busy), .done(done), .err(err),
        .active_cmd(active_cmd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) gcyc <= gcyc + 1;

    function automatic string kname(input int k);
        case (k)
            EV_BUSY: return "busy";
            EV_TOG:  return "tone";
            EV_DONE: return "done";
            default: return "err";
        endcase
    endfunction

    function automatic int half_of(input logic [2:0] c);
        case (c)
            3'b100:  return 2;
            3'b000:  return 3;
            3'b001:  return 4;
            3'b010:  return 5;
            3'b011:  return 6;
            default: return 0;
        endcase
    endfunction

    task automatic got(input int kind, input logic val);
        ev_t e;
        n_cmp++;
        if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: cyc=%0d %s=%0b, required no event",
                     gcyc, kname(kind), val);
        end else begin
            e = q.pop_front();
            if (e.cyc != gcyc || e.kind != kind || e.val !== val
                || e.cmd !== active_cmd) begin
                n_err++;
                $display("FAIL event: got cyc=%0d %s=%0b cmd=%b, required cyc=%0d %s=%0b cmd=%b",
                         gcyc, kname(kind), val, active_cmd,
                         e.cyc, kname(e.kind), e.val, e.cmd);
            end
        end
    endtask

    always @(negedge clk) begin
        if (busy !== mb) got(EV_BUSY, busy);
        if (tone !== mt) got(EV_TOG, tone);
        if (done === 1'b1) got(EV_DONE, 1'b1);
        if (err === 1'b1) got(EV_ERR, 1'b1);
        mb <= busy;
        mt <= tone;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int c, input int k, input logic v, input logic [2:0] m);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        e.val  = v;
        e.cmd  = m;
        q.push_back(e);
    endtask

    // Expected outputs per cycle of a burst accepted at cycle n;
    // cut >= 0 means the run is cancelled at the end of cycle cut.
    task automatic push_burst(input int n, input logic [2:0] c,
                              input int cut, input logic [2:0] ca);
        int         h;
        int         last;
        int         r;
        bit         pb, pt, b, t, d;
        logic [2:0] ec;
        h    = half_of(c);
        last = n + B + G + 1;
        if (cut >= 0 && cut + 1 < last) last = cut + 1;
        pb = 0;
        pt = 0;
        for (int cy = n + 1; cy <= last; cy++) begin
            r  = cy - n;
            ec = c;
            d  = 0;
            if (cut >= 0 && cy > cut) begin
                b  = 0;
                t  = 0;
                ec = ca;
            end else if (r <= B) begin
                b = 1;
                t = (((r - 1) / h) % 2) == 1;
            end else if (r <= B + G) begin
                b = 1;
                t = 0;
            end else begin
                b = 0;
                t = 0;
                d = 1;
            end
            if (b != pb) push(cy, EV_BUSY, b, ec);
            if (t != pt) push(cy, EV_TOG, t, ec);
            if (d) push(cy, EV_DONE, 1'b1, ec);
            pb = b;
            pt = t;
        end
    endtask

    task automatic go(input int c);
        while (gcyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_send(input logic [2:0] c, input int cut,
                           input logic [2:0] ca, input bit ab);
        int n;
        n     = gcyc;
        cmd   = c;
        send  = 1'b1;
        abort = ab;
        if (half_of(c) != 0) begin
            push_burst(n, c, cut, ca);
            last_cmd = c;
        end else begin
            push(n + 1, EV_ERR, 1'b1, last_cmd);
        end
        @(posedge clk);
        #1;
        send  = 1'b0;
        abort = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    int         n;
    logic [2:0] codes[4];
    logic [2:0] bad[3];

    initial begin
        rst   = 1'b1;
        send  = 1'b0;
        abort = 1'b0;
        cmd   = 3'b000;
        codes = '{3'b100, 3'b001, 3'b010, 3'b011};
        bad   = '{3'b111, 3'b110, 3'b101};
        #3;
        chk("rst_tone", int'(tone), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_active_cmd", int'(active_cmd), 4);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic STRAIGHT burst
        n = gcyc;
        do_send(3'b000, -1, 3'b000, 0);
        chk("basic_busy_n1", int'(busy), 1);
        go(n + 27);

        // Send while busy is ignored; send on the done cycle is taken
        n = gcyc;
        do_send(3'b000, -1, 3'b000, 0);
        go(n + 10);
        cmd  = 3'b001;
        send = 1'b1;
        @(posedge clk);
        #1;
        send = 1'b0;
        chk("busy_send_ignored_cmd", int'(active_cmd), 0);
        go(n + 26);
        do_send(3'b001, -1, 3'b001, 0);
        go(n + 26 + 27);

        // Frequency mapping
        foreach (codes[i]) begin
            n = gcyc;
            do_send(codes[i], -1, codes[i], 0);
            go(n + 27);
        end

        // Invalid codes
        foreach (bad[i]) begin
            n = gcyc;
            do_send(bad[i], -1, 3'b000, 0);
            chk("inv_busy", int'(busy), 0);
            chk("inv_tone", int'(tone), 0);
            chk("inv_active_cmd", int'(active_cmd), int'(last_cmd));
            go(n + 3);
        end

        // Abort during TONE
        n = gcyc;
        do_send(3'b000, n + 8, 3'b000, 0);
        go(n + 8);
        pulse_abort();
        chk("abort_tone_busy", int'(busy), 0);
        chk("abort_tone_tone", int'(tone), 0);
        go(n + 30);

        // Abort on the last GAP cycle
        n = gcyc;
        do_send(3'b010, n + 25, 3'b010, 0);
        go(n + 25);
        pulse_abort();
        chk("abort_gap_busy", int'(busy), 0);
        go(n + 30);

        // Abort in IDLE has no effect; send+abort together is accepted
        pulse_abort();
        chk("idle_abort_busy", int'(busy), 0);
        n = gcyc;
        do_send(3'b011, -1, 3'b011, 1);
        go(n + 27);

        // Asynchronous reset mid-burst
        n = gcyc;
        do_send(3'b000, n + 11, 3'b100, 0);
        go(n + 12);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_tone", int'(tone), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_active_cmd", int'(active_cmd), 4);
        last_cmd = 3'b100;
        @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Fresh burst after reset
        n = gcyc;
        do_send(3'b000, -1, 3'b000, 0);
        go(n + 27);

        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
